// File: rtl/nes_sdram_arbiter.sv
// Purpose: shares one SDRAM Avalon-MM master port between NREQ requesters, one transaction in flight.
// Latency: write req -> command next cycle -> ack the cycle after acceptance; read ack one cycle after readdatavalid.
// Backpressure: command held stable while avm_waitrequest=1; reads abort with err after TIMEOUT WAIT_RD cycles.
// Build option: define NES_ARB_RR_EN for round-robin among requesters 1..NREQ-1 (requester 0 always preempts).
module nes_sdram_arbiter #(
    parameter int NREQ    = 3,
    parameter int ADDR_W  = 24,
    parameter int TIMEOUT = 255
) (
    input  logic                   clk_50_clk,
    input  logic                   reset_reset_n,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ-1:0]        wr,
    input  logic [NREQ*ADDR_W-1:0] addr,
    input  logic [NREQ*16-1:0]     wdata,
    output logic [NREQ-1:0]        ack,
    output logic [15:0]            rdata,
    output logic                   err,
    output logic [ADDR_W-1:0]      avm_address,
    output logic                   avm_read,
    output logic                   avm_write,
    output logic [15:0]            avm_writedata,
    input  logic                   avm_waitrequest,
    input  logic [15:0]            avm_readdata,
    input  logic                   avm_readdatavalid
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_RD = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t            state;
    logic [IDX_W-1:0]  idx;
    logic [7:0]        cnt;
    logic [IDX_W-1:0]  win;
    logic [ADDR_W-1:0] sel_addr;
    logic [15:0]       sel_wdata;
    logic              sel_wr;
    logic              done_now;
    logic              timed_out;

`ifdef NES_ARB_RR_EN
    logic [IDX_W-1:0]  ptr;

    // Requester 0 first, otherwise rotate through 1..NREQ-1 starting after ptr
    always_comb begin
        int               c;
        logic             found;
        logic [IDX_W-1:0] cand;
        c     = 0;
        cand  = '0;
        found = 1'b0;
        win   = '0;
        if (req[0]) begin
            found = 1'b1;
        end
        for (int k = 1; k < NREQ; k++) begin
            c = int'(ptr) + k;
            if (c >= NREQ) begin
                c = c - (NREQ - 1);
            end
            cand = IDX_W'(c);
            if (!found && req[cand]) begin
                win   = cand;
                found = 1'b1;
            end
        end
    end

    // Pointer remembers the last RR-group winner; requester 0 leaves it alone
    always_ff @(posedge clk_50_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            ptr <= '0;
        end else if (done_now && idx != '0) begin
            ptr <= idx;
        end
    end
`else
    // Fixed priority: lowest requesting index wins
    always_comb begin
        win = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                win = IDX_W'(i);
            end
        end
    end
`endif

    // Pick the winner's fields out of the packed request buses
    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_wr    = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (win == IDX_W'(i)) begin
                sel_addr  = addr[i*ADDR_W +: ADDR_W];
                sel_wdata = wdata[i*16 +: 16];
                sel_wr    = wr[i];
            end
        end
    end

    // Completion this cycle: accepted write, read data in accept/wait cycle, or read abort
    always_comb begin
        timed_out = (state == WAIT_RD) && !avm_readdatavalid && (cnt == 8'(TIMEOUT));
        done_now  = ((state == ISSUE) && !avm_waitrequest && (avm_write || avm_readdatavalid)) ||
                    ((state == WAIT_RD) && (avm_readdatavalid || timed_out));
    end

    // Transaction FSM with registered Avalon command, ack, rdata and err
    always_ff @(posedge clk_50_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state         <= IDLE;
            idx           <= '0;
            cnt           <= '0;
            ack           <= '0;
            rdata         <= '0;
            err           <= 1'b0;
            avm_address   <= '0;
            avm_read      <= 1'b0;
            avm_write     <= 1'b0;
            avm_writedata <= '0;
        end else begin
            ack <= '0;
            if (done_now) begin
                ack <= NREQ'(1) << idx;
            end
            case (state)
                IDLE: begin
                    if (|req) begin
                        idx           <= win;
                        avm_address   <= sel_addr;
                        avm_writedata <= sel_wdata;
                        avm_write     <= sel_wr;
                        avm_read      <= !sel_wr;
                        state         <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (!avm_waitrequest) begin
                        avm_read  <= 1'b0;
                        avm_write <= 1'b0;
                        if (avm_write) begin
                            state <= DONE;
                        end else if (avm_readdatavalid) begin
                            rdata <= avm_readdata;
                            state <= DONE;
                        end else begin
                            cnt   <= '0;
                            state <= WAIT_RD;
                        end
                    end
                end
                WAIT_RD: begin
                    if (avm_readdatavalid) begin
                        rdata <= avm_readdata;
                        state <= DONE;
                    end else if (timed_out) begin
                        err   <= 1'b1;
                        rdata <= 16'hFFFF;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nes_sdram_arbiter.sv
// Directed bench for nes_sdram_arbiter: vector table of single transactions
// plus hand sequences for reset, stall, contention, timeout and mid-transaction reset.
module tb_nes_sdram_arbiter;
    localparam int NREQ   = 3;
    localparam int ADDR_W = 24;

    logic                   clk_50_clk = 1'b0;
    logic                   reset_reset_n = 1'b0;
    logic [NREQ-1:0]        req = '0;
    logic [NREQ-1:0]        wr = '0;
    logic [NREQ*ADDR_W-1:0] addr = '0;
    logic [NREQ*16-1:0]     wdata = '0;
    logic [NREQ-1:0]        ack;
    logic [15:0]            rdata;
    logic                   err;
    logic [ADDR_W-1:0]      avm_address;
    logic                   avm_read;
    logic                   avm_write;
    logic [15:0]            avm_writedata;
    logic                   avm_waitrequest = 1'b0;
    logic [15:0]            avm_readdata = '0;
    logic                   avm_readdatavalid = 1'b0;

    nes_sdram_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .TIMEOUT(255)) dut (
        .clk_50_clk        (clk_50_clk),
        .reset_reset_n     (reset_reset_n),
        .req               (req),
        .wr                (wr),
        .addr              (addr),
        .wdata             (wdata),
        .ack               (ack),
        .rdata             (rdata),
        .err               (err),
        .avm_address       (avm_address),
        .avm_read          (avm_read),
        .avm_write         (avm_write),
        .avm_writedata     (avm_writedata),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdata      (avm_readdata),
        .avm_readdatavalid (avm_readdatavalid)
    );

    always #10 clk_50_clk = ~clk_50_clk;

    typedef struct {
        logic [2:0]  rq;
        logic [2:0]  wm;
        logic [23:0] a;
        logic [15:0] d;
        logic [15:0] rd;
        int          dly;
        int          idx;
    } vec_t;

    vec_t        tbl[8];
    int          vectors = 0;
    int          miscompares = 0;
    logic [15:0] exp_rdata = '0;

    task automatic tick();
        @(posedge clk_50_clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Winner slice gets a/d, the other slices get the complement so a wrong pick shows up
    task automatic drive_bus(input logic [23:0] a, input logic [15:0] d, input int w);
        for (int i = 0; i < NREQ; i++) begin
            addr[i*ADDR_W +: ADDR_W] = (i == w) ? a : ~a;
            wdata[i*16 +: 16]        = (i == w) ? d : ~d;
        end
    endtask

    function automatic int idx_of(input logic [2:0] a);
        case (a)
            3'b001:  return 0;
            3'b010:  return 1;
            3'b100:  return 2;
            default: return 99;
        endcase
    endfunction

    initial begin
        int   got;
        int   n;
        int   exp_i;
        logic exp_wr;

        tbl[0] = '{3'b010, 3'b010, 24'h001234, 16'hBEEF, 16'h0000, 0, 1};
        tbl[1] = '{3'b100, 3'b000, 24'h800000, 16'h0000, 16'hA5A5, 0, 2};
        tbl[2] = '{3'b001, 3'b000, 24'h000001, 16'h0000, 16'h1234, 2, 0};
        tbl[3] = '{3'b011, 3'b001, 24'hFFFFFF, 16'h0000, 16'h0000, 0, 0};
        tbl[4] = '{3'b101, 3'b100, 24'h000000, 16'h0000, 16'hFFFE, 1, 0};
        tbl[5] = '{3'b111, 3'b111, 24'h123456, 16'h5A5A, 16'h0000, 0, 0};
        tbl[6] = '{3'b100, 3'b100, 24'hABCDEF, 16'hC3C3, 16'h0000, 0, 2};
        tbl[7] = '{3'b010, 3'b000, 24'h00FF00, 16'h0000, 16'h0F0F, 3, 1};

        // Reset held with all requests active
        req = 3'b111; wr = 3'b000;
        drive_bus(24'h0A0A0A, 16'h1111, 0);
        repeat (3) tick();
        chk("rst_ack", 32'(ack), 0);
        chk("rst_read", 32'(avm_read), 0);
        chk("rst_write", 32'(avm_write), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_rdata", 32'(rdata), 0);
        reset_reset_n = 1'b1;
        tick();
        chk("rel_read", 32'(avm_read), 1);
        chk("rel_addr", 32'(avm_address), 32'h0A0A0A);
        req = '0;
        avm_readdatavalid = 1'b1; avm_readdata = 16'h1357;
        tick();
        avm_readdatavalid = 1'b0;
        exp_rdata = 16'h1357;
        chk("rel_ack", 32'(ack), 32'b001);
        chk("rel_rdata", 32'(rdata), 32'(exp_rdata));
        tick();

        // Table of single transactions, no stall
        for (int v = 0; v < 8; v++) begin
            req = tbl[v].rq; wr = tbl[v].wm;
            drive_bus(tbl[v].a, tbl[v].d, tbl[v].idx);
            exp_wr = tbl[v].wm[tbl[v].idx];
            avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0;
            tick();
            req = '0;
            chk($sformatf("v%0d_write", v), 32'(avm_write), 32'(exp_wr));
            chk($sformatf("v%0d_read", v), 32'(avm_read), 32'(!exp_wr));
            chk($sformatf("v%0d_addr", v), 32'(avm_address), 32'(tbl[v].a));
            if (exp_wr) begin
                chk($sformatf("v%0d_wdata", v), 32'(avm_writedata), 32'(tbl[v].d));
                tick();
            end else begin
                avm_readdata = tbl[v].rd;
                avm_readdatavalid = (tbl[v].dly == 0);
                tick();
                for (int k = 1; k <= tbl[v].dly; k++) begin
                    avm_readdatavalid = (k == tbl[v].dly);
                    chk($sformatf("v%0d_noack_early", v), 32'(ack), 0);
                    tick();
                end
                avm_readdatavalid = 1'b0;
                exp_rdata = tbl[v].rd;
            end
            chk($sformatf("v%0d_ack", v), 32'(ack), 32'(3'b001 << tbl[v].idx));
            chk($sformatf("v%0d_rdata", v), 32'(rdata), 32'(exp_rdata));
            chk($sformatf("v%0d_cmd_off", v), 32'(avm_read | avm_write), 0);
            tick();
            chk($sformatf("v%0d_ack_pulse", v), 32'(ack), 0);
        end

        // Read stalled three cycles, data four cycles after acceptance
        req = 3'b100; wr = 3'b000; avm_waitrequest = 1'b1;
        drive_bus(24'h800000, 16'h0000, 2);
        tick();
        req = '0;
        drive_bus(24'h000000, 16'hFFFF, 2);
        for (int i = 0; i < 4; i++) begin
            chk("stall_read", 32'(avm_read), 1);
            chk("stall_addr", 32'(avm_address), 32'h800000);
            if (i == 3) avm_waitrequest = 1'b0;
            tick();
        end
        chk("stall_cmd_drop", 32'(avm_read), 0);
        avm_readdata = 16'hA5A5;
        for (int k = 1; k <= 4; k++) begin
            avm_readdatavalid = (k == 4);
            chk("stall_noack", 32'(ack), 0);
            tick();
        end
        avm_readdatavalid = 1'b0;
        exp_rdata = 16'hA5A5;
        chk("stall_ack", 32'(ack), 32'b100);
        chk("stall_rdata", 32'(rdata), 32'(exp_rdata));
        tick();

        // Contention: all three request, each drops after its ack
        req = 3'b111; wr = 3'b111;
        for (int i = 0; i < NREQ; i++) begin
            addr[i*ADDR_W +: ADDR_W] = 24'(i + 1);
        end
        for (int g = 0; g < 3; g++) begin
            got = -1;
            for (int c = 0; c < 10 && got < 0; c++) begin
                tick();
                if (ack != '0) begin
                    got = idx_of(ack);
                    req = req & ~ack;
                end
            end
            chk($sformatf("contend_order%0d", g), 32'(got), 32'(g));
        end
        tick();

        // Requesters 1 and 2 keep re-requesting
        req = 3'b110;
        for (int g = 0; g < 4; g++) begin
            got = -1;
            for (int c = 0; c < 10 && got < 0; c++) begin
                tick();
                if (ack != '0) begin
                    got = idx_of(ack);
                    if (g == 3) req = '0;
                end
            end
`ifdef NES_ARB_RR_EN
            exp_i = (g % 2 == 0) ? 1 : 2;
`else
            exp_i = 1;
`endif
            chk($sformatf("rerequest_order%0d", g), 32'(got), 32'(exp_i));
        end
        tick();

        // Read timeout
        req = 3'b001; wr = 3'b000;
        drive_bus(24'h00ABCD, 16'h0000, 0);
        tick();
        req = '0;
        tick();
        n = 0;
        while (ack == '0 && n < 300) begin
            tick();
            n++;
        end
        chk("timeout_ack", 32'(ack), 32'b001);
        chk("timeout_window", 32'(n >= 255 && n <= 257), 1);
        chk("timeout_rdata", 32'(rdata), 32'hFFFF);
        chk("timeout_err", 32'(err), 1);
        exp_rdata = 16'hFFFF;
        tick();

        // Stray readdatavalid in IDLE is ignored; err stays set across a write
        avm_readdatavalid = 1'b1; avm_readdata = 16'h1111;
        tick();
        avm_readdatavalid = 1'b0;
        chk("idle_rdv_ack", 32'(ack), 0);
        chk("idle_rdv_rdata", 32'(rdata), 32'(exp_rdata));
        req = 3'b010; wr = 3'b010;
        drive_bus(24'h000055, 16'h2222, 1);
        tick();
        req = '0;
        tick();
        chk("sticky_ack", 32'(ack), 32'b010);
        chk("sticky_err", 32'(err), 1);
        tick();

        // Reset while a stalled command is out
        req = 3'b001; wr = 3'b000; avm_waitrequest = 1'b1;
        tick();
        req = '0;
        chk("rst_issue_cmd", 32'(avm_read), 1);
        #2 reset_reset_n = 1'b0;
        #1;
        chk("rst_issue_drop", 32'(avm_read), 0);
        chk("rst_issue_err", 32'(err), 0);
        chk("rst_issue_rdata", 32'(rdata), 0);
        tick();
        reset_reset_n = 1'b1;
        avm_waitrequest = 1'b0;
        tick();

        // Reset in WAIT_RD, late readdatavalid afterwards
        req = 3'b001; wr = 3'b000;
        tick();
        req = '0;
        tick();
        tick();
        reset_reset_n = 1'b0;
        #1;
        chk("rst_wait_ack", 32'(ack), 0);
        tick();
        reset_reset_n = 1'b1;
        avm_readdatavalid = 1'b1; avm_readdata = 16'h7777;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("late_rdv_ack", 32'(ack), 0);
            chk("late_rdv_rdata", 32'(rdata), 0);
        end
        avm_readdatavalid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
